// File: rtl/tt_scan_pkg.sv
// Shared definitions for the truth-table scanner slice.
//   state_e      : scanner FSM states
//   ROW_W/CODE_W : row index width and truth-table code width
//   LAST_ROW     : final row of a 3-input table
//   row_to_bit() : maps a row index to its bit position in the code (row 0 -> MSB)
//   SETTLE_MIN / SAMPLES_MIN : lower bounds for the scanner parameters
package tt_scan_pkg;

  localparam int ROW_W       = 3;
  localparam int CODE_W      = 8;
  localparam int SETTLE_MIN  = 1;
  localparam int SAMPLES_MIN = 1;

  localparam logic [ROW_W-1:0] LAST_ROW = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  function automatic logic [ROW_W-1:0] row_to_bit(input logic [ROW_W-1:0] row);
    return ROW_W'(CODE_W - 1) - row;
  endfunction

endpackage

// File: rtl/tt_phase_counter.sv
// Loadable down-counter with terminal-count flag, shared by the settle and
// sample phases of the scanner.
//   clk, rst_n   : clock, async active-low reset
//   i_load       : load i_load_val (has priority over counting)
//   i_load_val   : phase length in cycles
//   i_en         : decrement while nonzero
//   o_count      : current count
//   o_tc         : high on the last cycle of the phase (count == 1)
module tt_phase_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == W'(1));

endmodule

// File: rtl/truth_table_scanner.sv
// Drives a 3-input truth-table gate through all 8 rows, waits a settle
// window per row, samples the gate output several times and assembles the
// 8-bit truth-table code, then compares it with a latched expected code.
//   clk, rst_n   : clock, async active-low reset
//   start        : scan request (accepted only when idle)
//   expected     : expected code, latched on start
//   dut_out      : output of the gate under test
//   in1/in2/in3  : gate inputs, {in1,in2,in3} = row index
//   busy         : scan in progress
//   done         : one-cycle completion pulse
//   code         : captured code, code[7-row] = row result
//   match        : code equals expected and all rows were stable
//   unstable     : some row produced disagreeing samples
module truth_table_scanner
  import tt_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int SAMPLES       = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CODE_W-1:0] expected,
  input  logic              dut_out,
  output logic              in1,
  output logic              in2,
  output logic              in3,
  output logic              busy,
  output logic              done,
  output logic [CODE_W-1:0] code,
  output logic              match,
  output logic              unstable
);

  localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] SAMPLES_LD = CNT_W'(SAMPLES);

  if (SETTLE_CYCLES < SETTLE_MIN) begin : g_bad_settle
    $error("truth_table_scanner: SETTLE_CYCLES must be >= 1");
  end
  if (SAMPLES < SAMPLES_MIN) begin : g_bad_samples
    $error("truth_table_scanner: SAMPLES must be >= 1");
  end

  state_e r_state, w_state_nxt;

  logic [ROW_W-1:0]  r_row;
  logic [CODE_W-1:0] r_expected;
  logic [CODE_W-1:0] r_code_acc;
  logic              r_unst_acc;
  logic              r_first_bit;
  logic [CODE_W-1:0] r_code;
  logic              r_match;
  logic              r_unstable;

  logic              w_cnt_load;
  logic [CNT_W-1:0]  w_cnt_load_val;
  logic              w_cnt_en;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_cnt_tc;
  logic              w_accept;
  logic              w_row_inc;
  logic              w_finish;
  logic              w_to_idle;

  logic              w_first;
  logic              w_diff;
  logic [CODE_W-1:0] w_code_nxt;
  logic              w_unst_nxt;

  tt_phase_counter #(
    .W (CNT_W)
  ) u_phase_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .i_en       (w_cnt_en),
    .o_count    (w_cnt),
    .o_tc       (w_cnt_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_load     = 1'b0;
    w_cnt_load_val = SETTLE_LD;
    w_cnt_en       = 1'b0;
    w_accept       = 1'b0;
    w_row_inc      = 1'b0;
    w_finish       = 1'b0;
    w_to_idle      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_SETTLE;
          w_cnt_load  = 1'b1;
          w_accept    = 1'b1;
        end
      end
      ST_SETTLE: begin
        w_cnt_en = 1'b1;
        if (w_cnt_tc) begin
          w_state_nxt    = ST_SAMPLE;
          w_cnt_load     = 1'b1;
          w_cnt_load_val = SAMPLES_LD;
        end
      end
      ST_SAMPLE: begin
        w_cnt_en = 1'b1;
        if (w_cnt_tc) begin
          if (r_row == LAST_ROW) begin
            w_state_nxt = ST_DONE;
            w_finish    = 1'b1;
          end else begin
            w_state_nxt = ST_SETTLE;
            w_cnt_load  = 1'b1;
            w_row_inc   = 1'b1;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_to_idle   = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The counter still holds the full SAMPLES value on the first sample edge.
  // Next-accumulator values are formed combinationally so the final sample
  // of row 7 is folded into the outputs on the same edge that enters DONE.
  always_comb begin
    w_first    = (r_state == ST_SAMPLE) && (w_cnt == SAMPLES_LD);
    w_diff     = (r_state == ST_SAMPLE) && !w_first && (dut_out != r_first_bit);
    w_code_nxt = r_code_acc;
    if (w_first) begin
      w_code_nxt[row_to_bit(r_row)] = dut_out;
    end
    w_unst_nxt = r_unst_acc | w_diff;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row       <= '0;
      r_expected  <= '0;
      r_code_acc  <= '0;
      r_unst_acc  <= 1'b0;
      r_first_bit <= 1'b0;
      r_code      <= '0;
      r_match     <= 1'b0;
      r_unstable  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_row       <= '0;
        r_expected  <= expected;
        r_code_acc  <= '0;
        r_unst_acc  <= 1'b0;
        r_first_bit <= 1'b0;
      end
      if (r_state == ST_SAMPLE) begin
        r_code_acc <= w_code_nxt;
        r_unst_acc <= w_unst_nxt;
        if (w_first) begin
          r_first_bit <= dut_out;
        end
      end
      if (w_row_inc) begin
        r_row <= r_row + ROW_W'(1);
      end
      if (w_finish) begin
        r_code     <= w_code_nxt;
        r_unstable <= w_unst_nxt;
        r_match    <= (w_code_nxt == r_expected) && !w_unst_nxt;
      end
      if (w_to_idle) begin
        r_row <= '0;
      end
    end
  end

  assign {in1, in2, in3} = r_row;
  assign busy     = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
  assign done     = (r_state == ST_DONE);
  assign code     = r_code;
  assign match    = r_match;
  assign unstable = r_unstable;

endmodule

// File: tb/tb_truth_table_scanner.sv
module tb_truth_table_scanner;

  localparam int SET      = 4;
  localparam int SMP      = 3;
  localparam int ROW_COST = SET + SMP;
  localparam int SCAN_LEN = 8 * ROW_COST;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] expected = '0;
  logic       dut_out;
  logic       in1, in2, in3;
  logic       busy, done, match, unstable;
  logic [7:0] code;

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus environment: gate truth table plus per-(row,sample) corruption.
  logic [7:0] gate_code = 8'hE9;
  bit         flip [8][SMP];
  bit         settle_noise = 1'b0;
  int         rel = 1000;        // edges elapsed since the start edge
  logic [7:0] last_code = '0;    // model value of the outputs' held code

  truth_table_scanner #(
    .SETTLE_CYCLES (SET),
    .SAMPLES       (SMP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .expected (expected),
    .dut_out  (dut_out),
    .in1      (in1),
    .in2      (in2),
    .in3      (in3),
    .busy     (busy),
    .done     (done),
    .code     (code),
    .match    (match),
    .unstable (unstable)
  );

  always #5 clk = ~clk;

  // Behavioural gate driven by the DUT's inputs, with corruption keyed to the
  // upcoming edge number of an ideal scan timeline.
  always_comb begin
    int  e;
    int  r;
    int  p;
    logic n;
    e = rel + 1;
    n = 1'b0;
    if (e >= 1 && e <= SCAN_LEN) begin
      r = (e - 1) / ROW_COST;
      p = (e - 1) % ROW_COST;
      if (p < SET) n = settle_noise && (e % 2 == 1);
      else         n = flip[r][p - SET];
    end
    dut_out = gate_code[3'd7 - {in1, in2, in3}] ^ n;
  end

  function automatic logic [7:0] model_code();
    logic [7:0] c;
    c = '0;
    for (int r = 0; r < 8; r++) c[7 - r] = gate_code[7 - r] ^ flip[r][0];
    return c;
  endfunction

  function automatic bit model_unstable();
    bit u;
    u = 1'b0;
    for (int r = 0; r < 8; r++)
      for (int s = 1; s < SMP; s++)
        if (flip[r][s] != flip[r][0]) u = 1'b1;
    return u;
  endfunction

  task automatic clear_inj();
    for (int r = 0; r < 8; r++)
      for (int s = 0; s < SMP; s++) flip[r][s] = 1'b0;
    settle_noise = 1'b0;
  endtask

  // Drives one scan and records what was observed; no judging here.
  task automatic do_scan(input logic [7:0] exp_v, input int start2_at, input int abort_at,
                         output int done_cyc, output int done_cnt, output int busy_bad,
                         output logic [7:0] code_early);
    @(negedge clk);
    expected = exp_v;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    expected   = ~exp_v;
    rel        = 0;
    done_cyc   = -1;
    done_cnt   = 0;
    busy_bad   = 0;
    code_early = code;
    if (busy !== 1'b1) busy_bad++;
    for (int i = 1; i <= SCAN_LEN + 4; i++) begin
      if (i == start2_at) begin
        start    = 1'b1;
        expected = exp_v ^ 8'h5A;
      end
      @(posedge clk);
      #1;
      rel   = i;
      start = 1'b0;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = i;
      end
      if (busy !== ((i < SCAN_LEN) ? 1'b1 : 1'b0)) busy_bad++;
      if (i == abort_at) return;
    end
    rel = 1000;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0)      begin n_errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_checks++; if (done !== 1'b0)      begin n_errors++; $display("FAIL reset_done got=%b want=0", done); end
    n_checks++; if (code !== 8'h00)     begin n_errors++; $display("FAIL reset_code got=%h want=00", code); end
    n_checks++; if (match !== 1'b0)     begin n_errors++; $display("FAIL reset_match got=%b want=0", match); end
    n_checks++; if (unstable !== 1'b0)  begin n_errors++; $display("FAIL reset_unstable got=%b want=0", unstable); end
    n_checks++; if ({in1, in2, in3} !== 3'b000) begin n_errors++; $display("FAIL reset_inputs got=%b want=000", {in1, in2, in3}); end
    @(negedge clk);
    rst_n = 1'b1;
    last_code = '0;
  endtask

  // One full scan with the current environment, checked against the model.
  task automatic scan_and_check(input string name, input logic [7:0] exp_v, input int start2_at);
    int dc, dn, bb;
    logic [7:0] ce, mc;
    bit mu, mm;
    mc = model_code();
    mu = model_unstable();
    mm = (mc == exp_v) && !mu;
    do_scan(exp_v, start2_at, 0, dc, dn, bb, ce);
    n_checks++; if (dc != SCAN_LEN) begin n_errors++; $display("FAIL %s_done_cycle got=%0d want=%0d", name, dc, SCAN_LEN); end
    n_checks++; if (dn != 1)        begin n_errors++; $display("FAIL %s_done_count got=%0d want=1", name, dn); end
    n_checks++; if (bb != 0)        begin n_errors++; $display("FAIL %s_busy_window bad_cycles=%0d want=0", name, bb); end
    n_checks++; if (ce !== last_code) begin n_errors++; $display("FAIL %s_code_hold got=%h want=%h", name, ce, last_code); end
    n_checks++; if (code !== mc)    begin n_errors++; $display("FAIL %s_code got=%h want=%h", name, code, mc); end
    n_checks++; if (match !== mm)   begin n_errors++; $display("FAIL %s_match got=%b want=%b", name, match, mm); end
    n_checks++; if (unstable !== mu) begin n_errors++; $display("FAIL %s_unstable got=%b want=%b", name, unstable, mu); end
    n_checks++; if ({in1, in2, in3} !== 3'b000) begin n_errors++; $display("FAIL %s_idle_inputs got=%b want=000", name, {in1, in2, in3}); end
    last_code = mc;
  endtask

  task automatic test_golden();
    clear_inj();
    gate_code = 8'hE9;
    scan_and_check("golden", 8'hE9, 0);
  endtask

  task automatic test_mismatch();
    clear_inj();
    gate_code = 8'hE9;
    scan_and_check("mismatch", 8'hE8, 0);
  endtask

  task automatic test_glitch();
    clear_inj();
    gate_code  = 8'hE9;
    flip[3][1] = 1'b1;
    scan_and_check("glitch", 8'hE9, 0);
  endtask

  task automatic test_settle_noise();
    clear_inj();
    gate_code    = 8'hE9;
    settle_noise = 1'b1;
    scan_and_check("settle", 8'hE9, 0);
  endtask

  task automatic test_start_while_busy();
    clear_inj();
    gate_code = 8'hE9;
    scan_and_check("busystart", 8'hE9, 20);
    scan_and_check("rescan", 8'hE9, 0);
  endtask

  task automatic test_reset_mid();
    int dc, dn, bb;
    logic [7:0] ce;
    bit saw_done;
    clear_inj();
    gate_code = 8'hE9;
    do_scan(8'hE9, 0, 30, dc, dn, bb, ce);
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0)     begin n_errors++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    n_checks++; if (code !== 8'h00)    begin n_errors++; $display("FAIL rstmid_code got=%h want=00", code); end
    n_checks++; if (match !== 1'b0 || unstable !== 1'b0) begin n_errors++; $display("FAIL rstmid_flags got=%b%b want=00", match, unstable); end
    n_checks++; if ({in1, in2, in3} !== 3'b000) begin n_errors++; $display("FAIL rstmid_inputs got=%b want=000", {in1, in2, in3}); end
    saw_done = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) saw_done = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    rel   = 1000;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
    end
    n_checks++; if (saw_done) begin n_errors++; $display("FAIL rstmid_no_done got=activity want=quiet"); end
    last_code = '0;
    scan_and_check("after_rst", 8'hE9, 0);
  endtask

  task automatic test_random();
    logic [7:0] exp_v;
    for (int it = 0; it < 10; it++) begin
      clear_inj();
      gate_code = 8'($urandom);
      for (int r = 0; r < 8; r++)
        for (int s = 0; s < SMP; s++) flip[r][s] = ($urandom_range(0, 19) == 0);
      settle_noise = 1'($urandom_range(0, 1));
      exp_v = ($urandom_range(0, 1) == 1) ? model_code() : 8'($urandom);
      scan_and_check($sformatf("rand%0d", it), exp_v, 0);
    end
  endtask

  initial begin
    clear_inj();
    test_reset();
    test_golden();
    test_mismatch();
    test_glitch();
    test_settle_noise();
    test_start_while_busy();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
